// File: rtl/sys_cfg_loader_if.sv
// PI-bus connection between the config loader (master) and the 8-byte mapper
// config register file (slave); pi_di is the register file's combinational readback.
interface sys_cfg_loader_if;
    logic [2:0] pi_addr;
    logic [7:0] pi_dato;
    logic       pi_ce_cfg;
    logic       pi_we_sync;
    logic [7:0] pi_di;

    modport master (
        output pi_addr, pi_dato, pi_ce_cfg, pi_we_sync,
        input  pi_di
    );

    modport slave (
        input  pi_addr, pi_dato, pi_ce_cfg, pi_we_sync,
        output pi_di
    );
endinterface

// File: rtl/sys_cfg_loader.sv
// Writes a latched 64-bit config image into the 8 mapper config registers, map_idx (reg 0) last.
// Optional readback check after each strobe is enabled by defining SYS_CFG_VERIFY_EN.
module sys_cfg_loader #(
    parameter int unsigned WR_GAP = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [63:0]      img,
    output logic             busy,
    output logic             done,
    output logic             err,
    sys_cfg_loader_if.master pi
);

    if (WR_GAP > 15) begin : g_wr_gap_range
        $error("sys_cfg_loader: WR_GAP must be in 0..15");
    end

    localparam bit         HAS_GAP  = (WR_GAP != 0);
    localparam logic [3:0] GAP_LOAD = (WR_GAP == 0) ? 4'd0 : 4'(WR_GAP - 1);

`ifdef SYS_CFG_VERIFY_EN
    typedef enum logic [2:0] {IDLE, SETUP, STROBE, VERIFY, GAP, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, SETUP, STROBE, GAP, DONE} state_t;
`endif

    state_t      state, state_d;
    logic [2:0]  idx;
    logic [3:0]  gap_cnt;
    logic [63:0] image;
    logic [7:0]  cur_byte;

    logic   accept, advance, load_gap, mismatch;
    state_t after_state;
    logic   after_adv;
    logic   last_reg;

    assign cur_byte = image[{idx, 3'b000} +: 8];
    assign last_reg = (idx == 3'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Where a register's write phase ends up: the gap if configured, else straight on.
    always_comb begin
        state_d     = state;
        accept      = 1'b0;
        advance     = 1'b0;
        load_gap    = 1'b0;
        mismatch    = 1'b0;
        after_state = HAS_GAP ? GAP : (last_reg ? DONE : SETUP);
        after_adv   = !HAS_GAP && !last_reg;
        case (state)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: state_d = STROBE;
`ifdef SYS_CFG_VERIFY_EN
            STROBE: state_d = VERIFY;
            VERIFY: begin
                if (pi.pi_di != cur_byte) begin
                    mismatch = 1'b1;
                    state_d  = DONE;
                end else begin
                    state_d  = after_state;
                    advance  = after_adv;
                    load_gap = HAS_GAP;
                end
            end
`else
            STROBE: begin
                state_d  = after_state;
                advance  = after_adv;
                load_gap = HAS_GAP;
            end
`endif
            GAP: begin
                if (gap_cnt == 4'd0) begin
                    if (last_reg) begin
                        state_d = DONE;
                    end else begin
                        advance = 1'b1;
                        state_d = SETUP;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Write order 1..7 then 0: the 3-bit index simply wraps after reg 7.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx     <= 3'd0;
            gap_cnt <= 4'd0;
            image   <= 64'd0;
        end else begin
            if (accept) begin
                image <= img;
                idx   <= 3'd1;
            end else if (advance) begin
                idx <= idx + 3'd1;
            end
            if (load_gap) begin
                gap_cnt <= GAP_LOAD;
            end else if (state == GAP) begin
                gap_cnt <= gap_cnt - 4'd1;
            end
        end
    end

`ifdef SYS_CFG_VERIFY_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= 1'b0;
        end else if (mismatch) begin
            err_q <= 1'b1;
        end
    end

    assign err          = err_q;
    assign pi.pi_ce_cfg = (state == SETUP) || (state == STROBE) || (state == VERIFY);
    assign busy         = (state == SETUP) || (state == STROBE) || (state == VERIFY) || (state == GAP);
`else
    logic unused_di;

    assign unused_di    = ^{pi.pi_di, mismatch};
    assign err          = 1'b0;
    assign pi.pi_ce_cfg = (state == SETUP) || (state == STROBE);
    assign busy         = (state == SETUP) || (state == STROBE) || (state == GAP);
`endif

    assign done          = (state == DONE);
    assign pi.pi_we_sync = (state == STROBE);
    assign pi.pi_addr    = idx;
    assign pi.pi_dato    = cur_byte;

endmodule

// File: tb/tb_sys_cfg_loader.sv
// Scoreboard bench for sys_cfg_loader: DUT a uses WR_GAP=2, DUT b uses WR_GAP=0.
// Expected strobes and done pulses are queued by the stimulus and consumed by a negedge monitor.
module tb_sys_cfg_loader;

`ifdef SYS_CFG_VERIFY_EN
    localparam int VER = 1;
`else
    localparam int VER = 0;
`endif
    localparam int GAP_A = 2;
    localparam int SP_B  = 2 + VER;

    typedef struct packed {
        logic [2:0] a;
        logic [7:0] v;
    } wr_t;

    typedef struct packed {
        int   c;
        int   b;
        logic e;
    } dn_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        start_a = 1'b0, start_b = 1'b0;
    logic [63:0] img_a = '0, img_b = '0;
    logic        busy_a, done_a, err_a, busy_b, done_b, err_b;
    logic        force_ff = 1'b0;
    logic [7:0]  regs [2][8];

    sys_cfg_loader_if bus_a ();
    sys_cfg_loader_if bus_b ();

    assign bus_a.pi_di = (force_ff && bus_a.pi_addr == 3'd4) ? 8'hFF : regs[0][bus_a.pi_addr];
    assign bus_b.pi_di = regs[1][bus_b.pi_addr];

    sys_cfg_loader #(.WR_GAP(GAP_A)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .img(img_a),
        .busy(busy_a), .done(done_a), .err(err_a), .pi(bus_a)
    );

    sys_cfg_loader #(.WR_GAP(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .img(img_b),
        .busy(busy_b), .done(done_b), .err(err_b), .pi(bus_b)
    );

    int  tests = 0;
    int  fails = 0;
    wr_t wr_q0[$], wr_q1[$];
    dn_t dn_q0[$], dn_q1[$];
    int  busy_cnt [2];
    int  last_wr  [2];
    int  ce_drop  [2];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic mon_step(input int d, input logic we, input logic [2:0] a, input logic [7:0] v,
                            input logic dn, input logic bs, input logic ce, input logic er);
        wr_t w;
        dn_t e;
        bit  have;
        if (bs) busy_cnt[d]++;
        if (bs && !ce) ce_drop[d] = 1;
        if (we) begin
            have = (d == 0) ? (wr_q0.size() > 0) : (wr_q1.size() > 0);
            tests++;
            if (!have) begin
                fails++;
                $display("FAIL strobe_extra dut%0d: actual strobe addr %0d data %02h, required none", d, a, v);
            end else begin
                if (d == 0) w = wr_q0.pop_front();
                else        w = wr_q1.pop_front();
                check("strobe_addr", 64'(a), 64'(w.a));
                check("strobe_data", 64'(v), 64'(w.v));
            end
            regs[d][a] = v;
            if (d == 1 && last_wr[1] >= 0) check("strobe_spacing", 64'(cyc - last_wr[1]), 64'(SP_B));
            last_wr[d] = cyc;
        end
        if (dn) begin
            have = (d == 0) ? (dn_q0.size() > 0) : (dn_q1.size() > 0);
            tests++;
            if (!have) begin
                fails++;
                $display("FAIL done_extra dut%0d: actual done at cycle %0d, required none", d, cyc);
            end else begin
                if (d == 0) e = dn_q0.pop_front();
                else        e = dn_q1.pop_front();
                check("done_cycle", 64'(cyc), 64'(e.c));
                check("busy_len", 64'(busy_cnt[d]), 64'(e.b));
                check("done_err", 64'(er), 64'(e.e));
                check("done_ce", 64'(ce), 64'd0);
                if (d == 1) check("ce_held", 64'(ce_drop[1]), 64'd0);
            end
            busy_cnt[d] = 0;
            last_wr[d]  = -1;
            ce_drop[d]  = 0;
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                busy_cnt[i] = 0;
                last_wr[i]  = -1;
                ce_drop[i]  = 0;
            end
        end else begin
            mon_step(0, bus_a.pi_we_sync, bus_a.pi_addr, bus_a.pi_dato, done_a, busy_a, bus_a.pi_ce_cfg, err_a);
            mon_step(1, bus_b.pi_we_sync, bus_b.pi_addr, bus_b.pi_dato, done_b, busy_b, bus_b.pi_ce_cfg, err_b);
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},  64'(busy_a), 64'd0);
        check({tag, "_done"},  64'(done_a), 64'd0);
        check({tag, "_err"},   64'(err_a), 64'd0);
        check({tag, "_addr"},  64'(bus_a.pi_addr), 64'd0);
        check({tag, "_dato"},  64'(bus_a.pi_dato), 64'd0);
        check({tag, "_ce"},    64'(bus_a.pi_ce_cfg), 64'd0);
        check({tag, "_we"},    64'(bus_a.pi_we_sync), 64'd0);
    endtask

    task automatic wait_idle(input int d);
        bit ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (d == 0 && !busy_a && !done_a) begin ok = 1; break; end
            if (d == 1 && !busy_b && !done_b) begin ok = 1; break; end
        end
        if (!ok) check("idle_timeout", 64'd1, 64'd0);
    endtask

    task automatic run_seq(input int d, input logic [63:0] im, input int abort_reg, input bit extra_start);
        int  order [8] = '{1, 2, 3, 4, 5, 6, 7, 0};
        int  per, nwr, blen, a0;
        bit  aborted;
        wr_t w;
        dn_t e;
        per     = 2 + ((d == 0) ? GAP_A : 0) + VER;
        nwr     = 8;
        blen    = 8 * per;
        aborted = 0;
        wait_idle(d);
        if (VER == 1 && abort_reg >= 0) begin
            for (int p = 0; p < 8; p++) begin
                if (order[p] == abort_reg) begin
                    nwr     = p + 1;
                    blen    = p * per + 3;
                    aborted = 1;
                end
            end
        end
        for (int p = 0; p < nwr; p++) begin
            w.a = 3'(order[p]);
            w.v = im[8 * order[p] +: 8];
            if (d == 0) wr_q0.push_back(w);
            else        wr_q1.push_back(w);
        end
        if (d == 0) begin start_a = 1'b1; img_a = im; end
        else        begin start_b = 1'b1; img_b = im; end
        @(posedge clk);
        #1;
        a0 = cyc;
        if (d == 0) begin start_a = 1'b0; img_a = ~im; check("err_clear", 64'(err_a), 64'd0); end
        else        begin start_b = 1'b0; img_b = ~im; check("err_clear", 64'(err_b), 64'd0); end
        e.c = a0 + blen;
        e.b = blen;
        e.e = aborted;
        if (d == 0) dn_q0.push_back(e);
        else        dn_q1.push_back(e);
        if (extra_start && d == 0) begin
            repeat (4) @(posedge clk);
            #1;
            start_a = 1'b1;
            img_a   = 64'h1122_3344_5566_7788;
            @(posedge clk);
            #1;
            start_a = 1'b0;
        end
    endtask

    function automatic logic [63:0] model_image(input int d);
        logic [63:0] m;
        for (int k = 0; k < 8; k++) m[8 * k +: 8] = regs[d][k];
        return m;
    endfunction

    localparam logic [63:0] IMG1 = 64'h8F0A_0B0C_0310_2A05;
    localparam logic [63:0] IMG2 = 64'h0123_4567_89AB_CDEF;

    initial begin
        bit hit;
        logic [7:0] t1_bytes [8] = '{8'h05, 8'h2A, 8'h10, 8'h03, 8'h0C, 8'h0B, 8'h0A, 8'h8F};
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 8; k++) regs[i][k] = 8'h00;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;

        // Basic load, then the same with a stray start mid-sequence.
        run_seq(0, IMG1, -1, 0);
        wait_idle(0);
        for (int k = 0; k < 8; k++) check("t1_reg", 64'(regs[0][k]), 64'(t1_bytes[k]));
        run_seq(0, IMG2, -1, 1);
        wait_idle(0);
        check("t2_image", model_image(0), IMG2);

        // Zero-gap instance.
        run_seq(1, IMG1, -1, 0);
        wait_idle(1);
        check("t4_image", model_image(1), IMG1);

        // Forced readback error on reg 4, then a clean run clears err.
        force_ff = 1'b1;
        run_seq(0, IMG1, 4, 0);
        wait_idle(0);
        check("t5_err_sticky", 64'(err_a), 64'(VER));
        force_ff = 1'b0;
        run_seq(0, IMG1, -1, 0);
        wait_idle(0);

        // Reset during the strobe of reg 3.
        wait_idle(0);
        for (int p = 1; p <= 3; p++) wr_q0.push_back(wr_t'{a: 3'(p), v: IMG2[8 * p +: 8]});
        start_a = 1'b1;
        img_a   = IMG2;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        hit = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #2;
            if (bus_a.pi_we_sync && bus_a.pi_addr == 3'd3) begin hit = 1; break; end
        end
        check("t3_reach_reg3", 64'(hit), 64'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t3");
        check("t3_pending", 64'(wr_q0.size()), 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        check("t3_quiet_busy", 64'(busy_a), 64'd0);
        run_seq(0, IMG1, -1, 0);
        wait_idle(0);
        check("t3_rerun", model_image(0), IMG1);

        // All-zero and all-one images.
        run_seq(0, 64'h0, -1, 0);
        wait_idle(0);
        check("t6_zero", model_image(0), 64'h0);
        run_seq(0, '1, -1, 0);
        wait_idle(0);
        check("t6_ones", model_image(0), 64'hFFFF_FFFF_FFFF_FFFF);
        check("t6_err", 64'(err_a), 64'd0);

        wait_idle(1);
        repeat (2) @(negedge clk);
        check("left_wr_a", 64'(wr_q0.size()), 64'd0);
        check("left_dn_a", 64'(dn_q0.size()), 64'd0);
        check("left_wr_b", 64'(wr_q1.size()), 64'd0);
        check("left_dn_b", 64'(dn_q1.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
